// File: rtl/hsid_ref_streamer.sv
// -----------------------------------------------------------------------------
// hsid_ref_streamer
//
// Producer side of the reference-FIFO path into hsid_main. Streams the HSP
// reference library from memory, one 32-bit word at a time, over an OBI-style
// read port and forwards each returned word straight into the reference FIFO.
// Each word packs two bands, so one reference vector is ceil(hsp_bands/2)
// words long. The write carrying the final word of a vector raises
// ref_word_last, and the final word of the library also raises ref_last.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, clear        begin a stream (sampled in idle) / abort it
//   hsp_bands           bands per reference vector
//   hsp_library_size    number of reference vectors
//   base_addr           word-aligned byte address of the first library word
//   mem_req/addr/gnt    read request channel
//   mem_rvalid/rdata    read response channel
//   fifo_ref_*          reference FIFO write side (wr_en, data, full)
//   ref_word_last       current write is the last word of a vector
//   ref_last            current write is the last word of the library
//   idle                streamer is idle
//   done/error/cancelled  one-cycle completion pulses
// -----------------------------------------------------------------------------
module hsid_ref_streamer #(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_BANDS_WIDTH   = 8,
  parameter int HSP_LIBRARY_WIDTH = 10,
  parameter int ADDR_WIDTH        = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         clear,
  input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
  input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_gnt,
  input  logic                         mem_rvalid,
  input  logic [WORD_WIDTH-1:0]        mem_rdata,
  output logic                         fifo_ref_wr_en,
  output logic [WORD_WIDTH-1:0]        fifo_ref_data,
  input  logic                         fifo_ref_full,
  output logic                         ref_word_last,
  output logic                         ref_last,
  output logic                         idle,
  output logic                         done,
  output logic                         error,
  output logic                         cancelled
);

  localparam logic [2:0] HR_IDLE   = 3'd0;
  localparam logic [2:0] HR_CONFIG = 3'd1;
  localparam logic [2:0] HR_REQ    = 3'd2;
  localparam logic [2:0] HR_WAIT   = 3'd3;
  localparam logic [2:0] HR_DONE   = 3'd4;
  localparam logic [2:0] HR_ERROR  = 3'd5;
  localparam logic [2:0] HR_CLEAR  = 3'd6;

  // One extra bit so (hsp_bands + 1) cannot overflow before the halving.
  localparam int WC_W = HSP_BANDS_WIDTH + 1;
  localparam logic [WC_W-1:0]              WC_ONE   = WC_W'(1);
  localparam logic [HSP_LIBRARY_WIDTH-1:0] LIB_ONE  = HSP_LIBRARY_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0]        ADDR_INC = ADDR_WIDTH'(4);

  logic [2:0]                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d;
  logic [WC_W-1:0]              word_count_q, word_count_d;
  logic [HSP_LIBRARY_WIDTH-1:0] ref_count_q, ref_count_d;
  logic [HSP_BANDS_WIDTH-1:0]   cfg_hsp_bands_q, cfg_hsp_bands_d;
  logic [HSP_LIBRARY_WIDTH-1:0] cfg_hsp_library_size_q, cfg_hsp_library_size_d;
  logic [WC_W-1:0]              cfg_words_q, cfg_words_d;
  // Set by an accepted request, cleared by its response. Lets HR_CLEAR wait
  // for (and swallow) a response that was already in flight.
  logic                         outstanding_q, outstanding_d;

  logic req_issue;
  logic beat;
  logic word_last;
  logic lib_last;

  assign req_issue = (state_q == HR_REQ) && !fifo_ref_full;
  assign beat      = (state_q == HR_WAIT) && mem_rvalid && !clear;
  assign word_last = (word_count_q == (cfg_words_q - WC_ONE));
  assign lib_last  = (ref_count_q == (cfg_hsp_library_size_q - LIB_ONE));

  always_comb begin
    state_d                = state_q;
    addr_d                 = addr_q;
    word_count_d           = word_count_q;
    ref_count_d            = ref_count_q;
    cfg_hsp_bands_d        = cfg_hsp_bands_q;
    cfg_hsp_library_size_d = cfg_hsp_library_size_q;
    cfg_words_d            = cfg_words_q;
    outstanding_d          = outstanding_q;

    mem_req        = req_issue;
    mem_addr       = (state_q == HR_REQ) ? addr_q : '0;
    fifo_ref_wr_en = beat;
    fifo_ref_data  = beat ? mem_rdata : '0;
    ref_word_last  = beat && word_last;
    ref_last       = beat && word_last && lib_last;
    idle           = (state_q == HR_IDLE);
    done           = 1'b0;
    error          = 1'b0;
    cancelled      = 1'b0;

    if (mem_rvalid) begin
      outstanding_d = 1'b0;
    end

    case (state_q)
      HR_IDLE: begin
        if (start) begin
          state_d = HR_CONFIG;
        end
      end

      HR_CONFIG: begin
        cfg_hsp_bands_d        = hsp_bands;
        cfg_hsp_library_size_d = hsp_library_size;
        cfg_words_d            = ({1'b0, hsp_bands} + WC_ONE) >> 1;
        addr_d                 = base_addr;
        word_count_d           = '0;
        ref_count_d            = '0;
        if (clear) begin
          state_d = HR_CLEAR;
        end else if ((hsp_bands == '0) || (hsp_library_size == '0)) begin
          state_d = HR_ERROR;
        end else begin
          state_d = HR_REQ;
        end
      end

      HR_REQ: begin
        // A grant coinciding with clear still leaves a response in flight.
        if (req_issue && mem_gnt) begin
          outstanding_d = 1'b1;
        end
        if (clear) begin
          state_d = HR_CLEAR;
        end else if (req_issue && mem_gnt) begin
          state_d = HR_WAIT;
        end
      end

      HR_WAIT: begin
        if (beat) begin
          addr_d = addr_q + ADDR_INC;
          if (word_last) begin
            word_count_d = '0;
            ref_count_d  = ref_count_q + LIB_ONE;
          end else begin
            word_count_d = word_count_q + WC_ONE;
          end
        end
        if (clear) begin
          state_d = HR_CLEAR;
        end else if (beat) begin
          state_d = (word_last && lib_last) ? HR_DONE : HR_REQ;
        end
      end

      HR_DONE, HR_ERROR: begin
        done  = (state_q == HR_DONE);
        error = (state_q == HR_ERROR);
      end

      HR_CLEAR: begin
        cancelled = !outstanding_q;
      end

      default: begin
        state_d = HR_IDLE;
      end
    endcase

    // Common exit path back to idle with counters and configuration wiped.
    if (done || error || cancelled || (state_q > HR_CLEAR)) begin
      state_d                = HR_IDLE;
      addr_d                 = '0;
      word_count_d           = '0;
      ref_count_d            = '0;
      cfg_hsp_bands_d        = '1;
      cfg_hsp_library_size_d = '1;
      cfg_words_d            = '1;
      outstanding_d          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                <= HR_IDLE;
      addr_q                 <= '0;
      word_count_q           <= '0;
      ref_count_q            <= '0;
      cfg_hsp_bands_q        <= '1;
      cfg_hsp_library_size_q <= '1;
      cfg_words_q            <= '1;
      outstanding_q          <= 1'b0;
    end else begin
      state_q                <= state_d;
      addr_q                 <= addr_d;
      word_count_q           <= word_count_d;
      ref_count_q            <= ref_count_d;
      cfg_hsp_bands_q        <= cfg_hsp_bands_d;
      cfg_hsp_library_size_q <= cfg_hsp_library_size_d;
      cfg_words_q            <= cfg_words_d;
      outstanding_q          <= outstanding_d;
    end
  end

endmodule

// File: tb/tb_hsid_ref_streamer.sv
// -----------------------------------------------------------------------------
// tb_hsid_ref_streamer
//
// Directed and randomized bench for hsid_ref_streamer. A small memory model
// answers requests with address-derived data after a randomized latency; a
// monitor records FIFO writes, granted addresses and the status pulses; each
// stream is compared against the write list expected from the band count,
// library size and base address.
// -----------------------------------------------------------------------------
module tb_hsid_ref_streamer;

  localparam int WW = 32;
  localparam int BW = 8;
  localparam int LW = 10;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic [BW-1:0] hsp_bands = '0;
  logic [LW-1:0] hsp_library_size = '0;
  logic [AW-1:0] base_addr = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [WW-1:0] mem_rdata = '0;
  logic          fifo_ref_wr_en;
  logic [WW-1:0] fifo_ref_data;
  logic          fifo_ref_full = 1'b0;
  logic          ref_word_last, ref_last, idle, done, error, cancelled;

  hsid_ref_streamer #(
    .WORD_WIDTH(WW), .HSP_BANDS_WIDTH(BW), .HSP_LIBRARY_WIDTH(LW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .hsp_bands(hsp_bands), .hsp_library_size(hsp_library_size), .base_addr(base_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fifo_ref_wr_en(fifo_ref_wr_en), .fifo_ref_data(fifo_ref_data),
    .fifo_ref_full(fifo_ref_full), .ref_word_last(ref_word_last), .ref_last(ref_last),
    .idle(idle), .done(done), .error(error), .cancelled(cancelled)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] mem_seed = 32'h1234_5678;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ mem_seed;
  endfunction

  // ---------------- memory model ----------------
  int          lat_min = 1, lat_max = 1, gdel_min = 0, gdel_max = 0;
  bit          gnt_block = 1'b0;

  initial begin : responder
    logic hs, rv, rq, rs;
    logic [31:0] a;
    logic [31:0] resp_addr;
    int   gcnt;
    int   rv_cnt;
    bit   m_out;
    gcnt = -1; rv_cnt = 0; m_out = 1'b0; resp_addr = '0;
    forever begin
      @(negedge clk);
      hs = mem_req && mem_gnt; rv = mem_rvalid; rq = mem_req; a = mem_addr; rs = rst;
      @(posedge clk);
      #1;
      if (rs) begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; m_out = 1'b0; gcnt = -1;
      end else begin
        if (rv) mem_rvalid = 1'b0;
        if (hs) begin
          mem_gnt = 1'b0; m_out = 1'b1; resp_addr = a; gcnt = -1;
          rv_cnt = int'($urandom_range(lat_max, lat_min));
        end else if (gnt_block) begin
          mem_gnt = 1'b0;
        end else if (rq && !mem_gnt) begin
          if (gcnt < 0) gcnt = int'($urandom_range(gdel_max, gdel_min));
          if (gcnt == 0) begin mem_gnt = 1'b1; gcnt = -1; end
          else gcnt--;
        end
        if (m_out) begin
          rv_cnt--;
          if (rv_cnt <= 0) begin mem_rvalid = 1'b1; m_out = 1'b0; end
        end
      end
      mem_rdata = mem_rvalid ? mem_word(resp_addr) : $urandom;
    end
  end

  // ---------------- monitor ----------------
  logic [33:0] cap_q[$];
  logic [31:0] cap_addr_q[$];
  int cyc = 0;
  int done_cnt, err_cnt, canc_cnt, req_cyc, req_full_viol;
  int done_cyc, err_cyc, canc_cyc, rv_cyc, last_wr_cyc, start_cyc;

  task automatic reset_counters();
    cap_q.delete(); cap_addr_q.delete();
    done_cnt = 0; err_cnt = 0; canc_cnt = 0; req_cyc = 0; req_full_viol = 0;
    done_cyc = -1; err_cyc = -1; canc_cyc = -1; rv_cyc = -1; last_wr_cyc = -1; start_cyc = -1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (fifo_ref_wr_en) begin
          cap_q.push_back({ref_word_last, ref_last, fifo_ref_data});
          last_wr_cyc = cyc;
        end
        if (mem_req && mem_gnt) cap_addr_q.push_back(mem_addr);
        if (mem_req) req_cyc++;
        if (mem_req && fifo_ref_full) req_full_viol++;
        if (mem_rvalid) rv_cyc = cyc;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (error) begin err_cnt++; err_cyc = cyc; end
        if (cancelled) begin canc_cnt++; canc_cyc = cyc; end
        if (start && idle) start_cyc = cyc;
      end
    end
  end

  // ---------------- reference model + stream runner ----------------
  logic [33:0] exp_d[$];
  logic [31:0] exp_a[$];

  task automatic run_stream(input int bands, input int lib, input logic [31:0] base,
                            input int hold_full, input bit rand_full, input string tag);
    int words;
    int n;
    bit bad;
    logic [31:0] a;
    bad = (bands == 0) || (lib == 0);
    words = (bands + 1) / 2;
    exp_d.delete(); exp_a.delete();
    if (!bad) begin
      for (int v = 0; v < lib; v++) begin
        for (int w = 0; w < words; w++) begin
          a = base + 32'(4 * (v * words + w));
          exp_a.push_back(a);
          exp_d.push_back({(w == words - 1), (v == lib - 1) && (w == words - 1), mem_word(a)});
        end
      end
    end
    reset_counters();
    hsp_bands = BW'(bands); hsp_library_size = LW'(lib); base_addr = base;
    start = 1'b1;
    if (hold_full > 0) fifo_ref_full = 1'b1;
    step();
    start = 1'b0;
    if (hold_full > 0) begin
      repeat (hold_full) step();
      check({tag, "_full_noreq"}, 64'(req_cyc), 64'd0);
      fifo_ref_full = 1'b0;
      #1;
      check({tag, "_req_on_release"}, 64'(mem_req), 64'd1);
    end
    for (int i = 0; i < 3000 && done_cnt == 0 && err_cnt == 0; i++) begin
      if (rand_full) fifo_ref_full = ($urandom_range(0, 3) == 0);
      step();
    end
    fifo_ref_full = 1'b0;
    check({tag, "_idle_after"}, 64'(idle), 64'd1);
    if (bad) begin
      check({tag, "_err_cnt"}, 64'(err_cnt), 64'd1);
      check({tag, "_err_cyc"}, 64'(err_cyc - start_cyc), 64'd2);
      check({tag, "_err_noreq"}, 64'(req_cyc), 64'd0);
      check({tag, "_err_nowr"}, 64'(cap_q.size()), 64'd0);
    end else begin
      n = (cap_q.size() < exp_d.size()) ? cap_q.size() : exp_d.size();
      check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      check({tag, "_wr_count"}, 64'(cap_q.size()), 64'(exp_d.size()));
      check({tag, "_addr_count"}, 64'(cap_addr_q.size()), 64'(exp_a.size()));
      for (int i = 0; i < n; i++)
        check($sformatf("%s_wr%0d", tag, i + 1), 64'(cap_q[i]), 64'(exp_d[i]));
      for (int i = 0; i < n && i < cap_addr_q.size(); i++)
        check($sformatf("%s_addr%0d", tag, i + 1), 64'(cap_addr_q[i]), 64'(exp_a[i]));
      check({tag, "_done_after_last"}, 64'(done_cyc - last_wr_cyc), 64'd1);
      check({tag, "_no_req_when_full"}, 64'(req_full_viol), 64'd0);
    end
    step();
    check({tag, "_single_pulse"}, 64'(done_cnt + err_cnt), 64'd1);
    $display("stream %s bands=%0d lib=%0d base=0x%0h writes=%0d done=%0d error=%0d",
             tag, bands, lib, base, cap_q.size(), done_cnt, err_cnt);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_idle"}, 64'(idle), 64'd1);
    check({tag, "_outs"}, 64'({mem_req, fifo_ref_wr_en, ref_word_last, ref_last,
                               done, error, cancelled}), 64'd0);
    check({tag, "_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_data"}, 64'(fifo_ref_data), 64'd0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin : main
    reset_counters();
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();
    mem_seed = $urandom;

    // Basic stream, 1-cycle rvalid, FIFO never full.
    run_stream(5, 3, 32'h0000_1000, 0, 1'b0, "basic");

    // Configuration errors.
    run_stream(0, 3, 32'h0000_1000, 0, 1'b0, "err_bands0");
    run_stream(4, 0, 32'h0000_1000, 0, 1'b0, "err_lib0");

    // FIFO full held while the streamer sits in HR_REQ.
    run_stream(4, 2, 32'h0000_2000, 10, 1'b0, "full_hold");

    // Clear while a response is outstanding.
    lat_min = 4; lat_max = 4;
    reset_counters();
    hsp_bands = 8'd4; hsp_library_size = 10'd2; base_addr = 32'h0000_3000;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 50 && cap_addr_q.size() == 0; i++) step();
    check("clrw_granted", 64'(cap_addr_q.size()), 64'd1);
    clear = 1'b1; step(); clear = 1'b0;
    check("clrw_not_yet_cancelled", 64'(cancelled), 64'd0);
    for (int i = 0; i < 50 && canc_cnt == 0; i++) step();
    check("clrw_cancel_cnt", 64'(canc_cnt), 64'd1);
    check("clrw_cancel_after_rvalid", 64'(canc_cyc - rv_cyc), 64'd1);
    check("clrw_no_write", 64'(cap_q.size()), 64'd0);
    check("clrw_idle", 64'(idle), 64'd1);
    step();
    check("clrw_cancel_once", 64'(canc_cnt), 64'd1);
    $display("clear-in-wait cancelled=%0d writes=%0d", canc_cnt, cap_q.size());
    lat_min = 1; lat_max = 1;
    run_stream(2, 1, 32'h0000_3000, 0, 1'b0, "after_clear");

    // Clear in HR_REQ with the grant withheld.
    gnt_block = 1'b1;
    reset_counters();
    hsp_bands = 8'd3; hsp_library_size = 10'd2; base_addr = 32'h0000_4000;
    start = 1'b1; step(); start = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("clrr_req_held%0d", i), 64'(mem_req), 64'd1);
      if (i < 3) step();
    end
    clear = 1'b1; step(); clear = 1'b0;
    check("clrr_req_dropped", 64'(mem_req), 64'd0);
    check("clrr_cancelled", 64'(cancelled), 64'd1);
    step();
    check("clrr_cancel_pulse", 64'(cancelled), 64'd0);
    check("clrr_idle", 64'(idle), 64'd1);
    check("clrr_no_grant_no_write", 64'(cap_q.size() + cap_addr_q.size()), 64'd0);
    check("clrr_cancel_cnt", 64'(canc_cnt), 64'd1);
    $display("clear-in-req cancelled=%0d", canc_cnt);
    gnt_block = 1'b0;

    // Reset while a response is outstanding.
    lat_min = 6; lat_max = 6;
    reset_counters();
    hsp_bands = 8'd1; hsp_library_size = 10'd1; base_addr = 32'h0000_5000;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 50 && cap_addr_q.size() == 0; i++) step();
    check("rstw_granted", 64'(cap_addr_q.size()), 64'd1);
    rst = 1'b1; step();
    check_reset_outputs("rstw");
    rst = 1'b0;
    lat_min = 1; lat_max = 1;
    repeat (8) step();
    check("rstw_no_write", 64'(cap_q.size()), 64'd0);
    $display("reset-in-wait idle=%0d", idle);
    run_stream(1, 1, 32'h0000_5000, 0, 1'b0, "after_rst");

    // Randomized streams with variable latency, grant delay and backpressure.
    for (int t = 0; t < 10; t++) begin
      logic [31:0] b;
      lat_min = 1; lat_max = 3; gdel_min = 0; gdel_max = 2;
      b = (t == 9) ? 32'hFFFF_FFF8 : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      run_stream(int'($urandom_range(1, 9)), int'($urandom_range(1, 4)), b, 0, 1'b1,
                 $sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
